// File: rtl/link_supervisor.sv
// Arming / failsafe sequencer between the RC channel decoder and the motor/steer stages.
// Watches per-channel capture activity for signal loss. Arming needs a run of
// neutral-throttle power frames. Power, steer and brake are forced to safe values
// whenever the sequencer is not ARMED.
module link_supervisor #(
  parameter int K_NCHAN      = 4,
  parameter int K_RES        = 10,
  parameter int K_TIMEOUT    = 25,
  parameter int K_ARM_FRAMES = 10,
  parameter int K_NEUTRAL    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_timebase,
  input  logic [K_NCHAN-1:0] i_capture_done,
  input  logic               i_power_valid,
  input  logic               i_enable,
  input  logic [K_RES-1:0]   i_power,
  input  logic [K_RES-1:0]   i_steer,
  input  logic               i_brake,
  output logic [K_RES-1:0]   o_power,
  output logic [K_RES-1:0]   o_steer,
  output logic               o_brake,
  output logic               o_armed,
  output logic               o_failsafe,
  output logic               o_link_ok
);

  localparam int CW = $clog2(K_TIMEOUT + 1);
  localparam int FW = $clog2(K_ARM_FRAMES + 1);
  localparam logic [CW-1:0]    T_MAX  = CW'(K_TIMEOUT);
  localparam logic [FW-1:0]    F_MAX  = FW'(K_ARM_FRAMES);
  localparam logic [K_RES-1:0] S_MAX  = {1'b0, {(K_RES-1){1'b1}}};
  localparam logic [K_RES-1:0] S_MIN  = {1'b1, {(K_RES-1){1'b0}}};
  localparam logic [K_RES-1:0] NEUT_T = K_RES'(K_NEUTRAL);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  logic [CW-1:0]    cnt_r [K_NCHAN];
  logic [K_NCHAN-1:0] lost_s;
  logic             link_ok_s;
  logic [K_RES-1:0] abs_s;
  logic             neutral_s;
  state_t           state_r;
  state_t           next_s;
  logic [FW-1:0]    fcnt_r;
  logic [FW-1:0]    fcnt_next_s;

  // Per-channel silence counters; preset to the timeout so the link starts as lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < K_NCHAN; i++) cnt_r[i] <= T_MAX;
    end else begin
      for (int i = 0; i < K_NCHAN; i++) begin
        if (i_capture_done[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (i_timebase && (cnt_r[i] != T_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // A channel is lost once its counter has saturated.
  always_comb begin
    lost_s = {K_NCHAN{1'b0}};
    for (int i = 0; i < K_NCHAN; i++) lost_s[i] = (cnt_r[i] == T_MAX);
  end

  assign link_ok_s = ~|lost_s;

  // Throttle magnitude; the most negative code saturates instead of wrapping to itself.
  always_comb begin
    if (!i_power[K_RES-1]) begin
      abs_s = i_power;
    end else if (i_power == S_MIN) begin
      abs_s = S_MAX;
    end else begin
      abs_s = ~i_power + K_RES'(1);
    end
  end

  assign neutral_s = (abs_s < NEUT_T);

  // Next-state decode: disable beats link loss, link loss beats everything else.
  always_comb begin
    next_s      = state_r;
    fcnt_next_s = fcnt_r;
    case (state_r)
      DISARMED: begin
        if (link_ok_s && i_enable && i_power_valid && neutral_s) begin
          fcnt_next_s = FW'(1);
          next_s      = (K_ARM_FRAMES == 1) ? ARMED : ARMING;
        end else begin
          next_s = DISARMED;
        end
      end
      ARMING: begin
        if (!i_enable || !link_ok_s) begin
          next_s = DISARMED;
        end else if (i_power_valid && !neutral_s) begin
          next_s = DISARMED;
        end else if (i_power_valid) begin
          fcnt_next_s = fcnt_r + FW'(1);
          next_s      = ((fcnt_r + FW'(1)) == F_MAX) ? ARMED : ARMING;
        end else begin
          next_s = ARMING;
        end
      end
      ARMED: begin
        if (!i_enable) begin
          next_s = DISARMED;
        end else if (!link_ok_s) begin
          next_s = FAILSAFE;
        end else begin
          next_s = ARMED;
        end
      end
      FAILSAFE: begin
        // Recovery waits for a tick seen with the link healthy; never straight back to ARMED.
        if (!i_enable) begin
          next_s = DISARMED;
        end else if (link_ok_s && i_timebase) begin
          next_s = DISARMED;
        end else begin
          next_s = FAILSAFE;
        end
      end
      default: begin
        next_s      = DISARMED;
        fcnt_next_s = {FW{1'b0}};
      end
    endcase
  end

  // State, frame counter and gated outputs, all registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= DISARMED;
      fcnt_r     <= {FW{1'b0}};
      o_power    <= {K_RES{1'b0}};
      o_steer    <= {K_RES{1'b0}};
      o_brake    <= 1'b1;
      o_armed    <= 1'b0;
      o_failsafe <= 1'b0;
      o_link_ok  <= 1'b0;
    end else begin
      state_r    <= next_s;
      fcnt_r     <= fcnt_next_s;
      o_armed    <= (next_s == ARMED);
      o_failsafe <= (next_s == FAILSAFE);
      o_link_ok  <= link_ok_s;
      if (next_s == ARMED) begin
        o_power <= i_power;
        o_steer <= i_steer;
        o_brake <= i_brake;
      end else begin
        o_power <= {K_RES{1'b0}};
        o_steer <= {K_RES{1'b0}};
        o_brake <= 1'b1;
      end
    end
  end

endmodule
